// File: rtl/mem_arbiter_if.sv
// Avalon-MM bundle for the two-master arbiter: instruction port, data port,
// shared cache port and the grant status.
interface mem_arbiter_if;
  logic [31:0] i_address;
  logic        i_read;
  logic        i_waitrequest;
  logic [31:0] i_readdata;

  logic [31:0] d_address;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_writedata;
  logic [3:0]  d_byteenable;
  logic        d_waitrequest;
  logic [31:0] d_readdata;

  logic [31:0] m_address;
  logic        m_read;
  logic        m_write;
  logic [31:0] m_writedata;
  logic [3:0]  m_byteenable;
  logic        m_waitrequest;
  logic [31:0] m_readdata;

  logic [1:0]  grant;

  // Arbiter side: slave to both CPU ports, master toward the cache.
  modport slave (
    input  i_address, i_read,
    output i_waitrequest, i_readdata,
    input  d_address, d_read, d_write, d_writedata, d_byteenable,
    output d_waitrequest, d_readdata,
    output m_address, m_read, m_write, m_writedata, m_byteenable,
    input  m_waitrequest, m_readdata,
    output grant
  );

  // Environment side: CPU ports and cache model.
  modport master (
    output i_address, i_read,
    input  i_waitrequest, i_readdata,
    output d_address, d_read, d_write, d_writedata, d_byteenable,
    input  d_waitrequest, d_readdata,
    input  m_address, m_read, m_write, m_writedata, m_byteenable,
    output m_waitrequest, m_readdata,
    input  grant
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master Avalon-MM arbiter sharing one cache bus between the instruction
// and data ports; one whole transaction granted at a time.
module mem_arbiter #(
  parameter bit DATA_PRIORITY = 1'b0
) (
  input  logic clk,
  input  logic reset,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_I = 2'd1,
    OWN_D = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_last_d;
  logic   w_last_d_nxt;
  logic   w_req_i;
  logic   w_req_d;

  assign w_req_i = bus.i_read;
  assign w_req_d = bus.d_read | bus.d_write;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_last_d <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_last_d <= w_last_d_nxt;
    end
  end

  // Ownership ends on completion or when the owner abandons its request.
  always_comb begin
    w_state_nxt  = r_state;
    w_last_d_nxt = r_last_d;
    unique case (r_state)
      IDLE: begin
        if (w_req_i && w_req_d)
          w_state_nxt = (DATA_PRIORITY || !r_last_d) ? OWN_D : OWN_I;
        else if (w_req_i)
          w_state_nxt = OWN_I;
        else if (w_req_d)
          w_state_nxt = OWN_D;
      end
      OWN_I: begin
        if (!w_req_i || !bus.m_waitrequest) begin
          w_state_nxt  = IDLE;
          w_last_d_nxt = 1'b0;
        end
      end
      OWN_D: begin
        if (!w_req_d || !bus.m_waitrequest) begin
          w_state_nxt  = IDLE;
          w_last_d_nxt = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.m_address     = '0;
    bus.m_read        = 1'b0;
    bus.m_write       = 1'b0;
    bus.m_writedata   = '0;
    bus.m_byteenable  = '0;
    bus.grant         = 2'b00;
    bus.i_waitrequest = 1'b1;
    bus.i_readdata    = '0;
    bus.d_waitrequest = 1'b1;
    bus.d_readdata    = '0;
    unique case (r_state)
      OWN_I: begin
        bus.grant        = 2'b01;
        bus.m_address    = bus.i_address;
        bus.m_read       = bus.i_read;
        bus.m_byteenable = '1;
        if (bus.i_read && !bus.m_waitrequest) begin
          bus.i_waitrequest = 1'b0;
          bus.i_readdata    = bus.m_readdata;
        end
      end
      OWN_D: begin
        // Simultaneous read and write is illegal; the write is forwarded.
        bus.grant        = 2'b10;
        bus.m_address    = bus.d_address;
        bus.m_read       = bus.d_read & ~bus.d_write;
        bus.m_write      = bus.d_write;
        bus.m_writedata  = bus.d_writedata;
        bus.m_byteenable = bus.d_byteenable;
        if (w_req_d && !bus.m_waitrequest) begin
          bus.d_waitrequest = 1'b0;
          bus.d_readdata    = bus.m_readdata;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master Avalon-MM arbiter that shares the single memory/cache bus between the CPU's instruction-fetch port and data port. Sits between the MIPS core and the cache module; each CPU port sees a private Avalon slave, the cache sees one Avalon master. It grants one complete transaction at a time, round-robin or fixed data priority, and stalls the losing port via its waitrequest.

## Interface
- DATA_PRIORITY, 0, 0 = round-robin between ports; 1 = data port always wins contention
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- i_address  in  32  instruction fetch address
- i_read  in  1  instruction read request (port is read-only)
- i_waitrequest  out  1  stall to instruction port
- i_readdata  out  32  fetched word
- d_address  in  32  data address
- d_read  in  1  data read request
- d_write  in  1  data write request
- d_writedata  in  32  store data
- d_byteenable  in  4  store/load byte lanes
- d_waitrequest  out  1  stall to data port
- d_readdata  out  32  load word
- m_address  out  32  address to cache
- m_read  out  1  read to cache
- m_write  out  1  write to cache
- m_writedata  out  32  write data to cache
- m_byteenable  out  4  byte lanes to cache
- m_waitrequest  in  1  cache stall
- m_readdata  in  32  cache read data
- grant  out  2  {data owns, instr owns}, one-hot or 00

## Operation
- States: IDLE, OWN_I, OWN_D. Register last_owner (I/D).
- IDLE: m_read=m_write=0, m_address=0, m_writedata=0, m_byteenable=0, grant=00. Requests: req_i=i_read, req_d=d_read|d_write.
  - Only one request -> next state OWN of that port.
  - Both requests: DATA_PRIORITY=1 -> OWN_D; else the port that is not last_owner wins.
  - None -> stay IDLE.
- OWN_I: m_address=i_address, m_read=i_read, m_write=0, m_byteenable=4'hF, m_writedata=0.
- OWN_D: m_address=d_address, m_read=d_read&~d_write, m_write=d_write, m_writedata=d_writedata, m_byteenable=d_byteenable. d_read and d_write both high is a protocol violation; write wins.
- Completion: in OWN_x, cycle with m_waitrequest=0 and owner's request high. That cycle: owner's waitrequest=0, owner's readdata=m_readdata; last_owner<=x; next state IDLE.
- Owner drops its request while m_waitrequest=1 (illegal Avalon): no completion signalled, last_owner<=x, next state IDLE.
- Port waitrequest = 0 only in its completion cycle; 1 otherwise, including while idle and not requesting. Non-owner readdata = 0.
- All m_* and grant are pure functions of state and owner inputs; only state and last_owner are registered.
- Reset (asserted): state=IDLE, last_owner=D (instruction wins first contention). All outputs immediately take IDLE values; i/d_waitrequest=1, readdata=0. Transaction in flight is abandoned; the cache must tolerate a dropped request.

## Timing
- Arbitration costs one cycle: request sampled in IDLE at edge N, ownership from cycle N+1.
- Zero-wait cache: request to completion = 2 cycles; one port's max throughput 1 transaction / 2 cycles.
- Each cache wait-state cycle adds one cycle; the owner's signals are forwarded unchanged throughout.
- Worst-case latency under contention (round-robin): own 2 + other's full transaction.
- Request arriving during the other port's OWN state is queued implicitly (port held in waitrequest) and arbitrated at the next IDLE.
- Reset deassertion synchronous to clk by the system; first arbitration on the first edge after release.

## Test plan
- Reset low mid-run -> grant=00, m_read=m_write=0, m_address=0, i_waitrequest=d_waitrequest=1 immediately, no clock needed.
- i_read, i_address=0xBFC00000, cache zero-wait returns 0x24020005 -> cycle 1: grant=01, m_read=1, m_address=0xBFC00000, m_byteenable=F, i_waitrequest=0, i_readdata=0x24020005; cycle 2 IDLE.
- After reset, i_read and d_write (0x00001000, 0xDEADBEEF, be=0x3) same cycle -> instruction served first, then IDLE, then OWN_D with m_write=1, m_writedata=0xDEADBEEF, m_byteenable=3; d_waitrequest high until its completion cycle.
- Both ports continuously requesting, DATA_PRIORITY=0 -> grants I,D,I,D over 8 cycles; with DATA_PRIORITY=1 -> D every transaction, I starved.
- d_read of 0x2000, m_waitrequest high 3 cycles then low with 0x12345678 -> m_* stable 4 cycles, d_waitrequest=0 only in 4th, d_readdata=0x12345678.
- Owner drops request while m_waitrequest=1, then reset asserted during later OWN_D -> return to IDLE without completion, last_owner updated; reset forces IDLE and next contention grants instruction.
